// File: rtl/pseudo_softmax_pkg.sv
// Shared types and constants for the pseudo-softmax normalizer.
// Holds the FSM state type, fixed-point widths and the saturation value.
package pseudo_softmax_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int unsigned FRAC_W    = 7;
    localparam int unsigned LN_W      = 16;
    localparam int unsigned SAT_VAL   = 255;
    localparam int unsigned T_W       = LN_W + 1;
    localparam int unsigned P_W       = 8;
    localparam int unsigned CNT_W     = 9;
    localparam int unsigned MAX_SHIFT = P_W + 1;

endpackage

// File: rtl/pow2_mitchell.sv
// Mitchell antilog: maps a signed Q.7 log2 difference to a Q0.8 probability.
// Non-negative inputs saturate and shifts of MAX_SHIFT or more underflow to zero.
module pow2_mitchell
    import pseudo_softmax_pkg::*;
(
    input  logic [16:0] t,
    output logic [7:0]  p
);

    logic signed [T_W-1:0] int_part;
    logic [T_W-1:0]        n;
    logic [P_W:0]          mant;

    // Floor of t/128 gives the integer exponent; the low bits are the mantissa fraction.
    always_comb begin
        int_part = $signed(t) >>> FRAC_W;
        n        = T_W'(-int_part);
        mant     = {1'b1, t[FRAC_W-1:0], 1'b0};
        p        = '0;
        if (!t[T_W-1]) begin
            p = P_W'(SAT_VAL);
        end else if (n < T_W'(MAX_SHIFT)) begin
            p = P_W'(mant >> n[3:0]);
        end
    end

endmodule

// File: rtl/pseudo_softmax_normalizer.sv
// Frame-based pseudo-softmax: subtracts the frame log-sum from each element
// exponent and converts the difference back to a Q0.8 probability.
module pseudo_softmax_normalizer
    import pseudo_softmax_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sum_valid,
    output logic       sum_ready,
    input  logic [8:0] sum_exp,
    input  logic [7:0] sum_mant,
    input  logic [7:0] frame_len,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_x,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_p,
    output logic       out_last,
    output logic       done
);

    state_e           state;
    state_e           state_next;
    logic [LN_W-1:0]  ln_sum;
    logic [CNT_W-1:0] frame_n;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             s1_valid;
    logic             s1_last;
    logic [T_W-1:0]   s1_t;
    logic [P_W-1:0]   p_c;
    logic             s2_adv;
    logic             s1_adv;
    logic             load;
    logic             in_acc;
    logic             out_acc;
    logic             in_final;
    logic             out_final;

    // Handshake and pipeline-advance terms; sum_ready is held low while in reset.
    always_comb begin
        s2_adv    = !out_valid || out_ready;
        s1_adv    = !s1_valid || s2_adv;
        sum_ready = (state == IDLE) && !rst;
        in_ready  = (state == RUN) && (in_cnt < frame_n) && s1_adv;
        load      = sum_valid && sum_ready;
        in_acc    = in_valid && in_ready;
        out_acc   = out_valid && out_ready;
        in_final  = (in_cnt == frame_n - CNT_W'(1));
        out_final = out_acc && (out_cnt == frame_n - CNT_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = RUN;
            RUN:     if (in_acc && in_final) state_next = DRAIN;
            DRAIN:   if (out_final) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame context and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ln_sum  <= '0;
            frame_n <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            done    <= 1'b0;
        end else begin
            if (load) begin
                ln_sum  <= (LN_W'(sum_exp) << FRAC_W) + LN_W'(sum_mant) - LN_W'(128);
                frame_n <= (frame_len == '0) ? CNT_W'(256) : CNT_W'(frame_len);
                in_cnt  <= '0;
                out_cnt <= '0;
            end
            if (in_acc) begin
                in_cnt <= in_cnt + CNT_W'(1);
            end
            if (out_acc) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end
            done <= out_final;
        end
    end

    // Two-stage pipeline: stage 1 holds the log difference, stage 2 is the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_t      <= '0;
            out_valid <= 1'b0;
            out_p     <= '0;
            out_last  <= 1'b0;
        end else begin
            if (in_acc) begin
                s1_valid <= 1'b1;
                s1_t     <= (T_W'(in_x) << FRAC_W) - T_W'(ln_sum);
                s1_last  <= in_final;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                out_p     <= s1_valid ? p_c : '0;
                out_last  <= s1_valid && s1_last;
            end
        end
    end

    pow2_mitchell u_pow2 (
        .t (s1_t),
        .p (p_c)
    );

endmodule

// File: doc/pseudo_softmax_normalizer.md
PSEUDO_SOFTMAX_NORMALIZER -- requirements
Module: pseudo_softmax_normalizer

Interface
REQ-001 SHALL have ports clk (in, 1, sole clock, rising edge) and rst (in, 1, asynchronous, active-high reset).
REQ-002 SHALL have sum_valid in 1 and sum_ready out 1: load handshake for the frame log-sum.
REQ-003 SHALL have sum_exp in 9: integer exponent from the adder tree.
REQ-004 SHALL have sum_mant in 8: Q1.7 mantissa, legal range 128..255.
REQ-005 SHALL have frame_len in 8: elements per frame; 0 means 256.
REQ-006 SHALL have in_valid in 1, in_ready out 1 and in_x in 8: unsigned element exponent stream.
REQ-007 SHALL have out_valid out 1, out_ready in 1, out_p out 8 (Q0.8 probability) and out_last out 1.
REQ-008 SHALL have done out 1: one-cycle pulse when the frame completes.

Function
REQ-009 SHALL use FSM states IDLE, RUN, DRAIN; sum_ready=1 only in IDLE.
REQ-010 SHALL, on IDLE with sum_valid, register L = sum_exp*128 + (sum_mant-128) (16-bit unsigned, Mitchell log2), latch frame_len, clear counters, and go to RUN.
REQ-011 SHALL assert in_ready = RUN and in_cnt<N and stage-1 free-or-advancing; stage 1 advances when stage 2 is empty or advancing; stage 2 advances when out_valid=0 or out_ready=1.
REQ-012 SHALL compute in stage 1 t = in_x*128 - L as 17-bit signed and register it.
REQ-013 SHALL compute in stage 2: t>=0 gives out_p=255; otherwise n = -(t>>>7), f = t[6:0], out_p = ((128+f)*2) >> n (9-bit), and n>=9 gives 0.
REQ-014 SHALL have latency of exactly 2 cycles from the in accept edge to out_valid with no back-pressure, and throughput of 1 element/cycle.
REQ-015 SHALL hold out_p/out_last stable while out_valid=1 and out_ready=0, with no drops or duplicates.
REQ-016 SHALL raise out_last with the N-th output; done pulses the cycle after the N-th output is accepted.
REQ-017 SHALL move to DRAIN when in_cnt reaches N and to IDLE on the final out accept; out_cnt and in_cnt are 9-bit.
REQ-018 SHALL ignore sum_valid outside IDLE; in_valid outside RUN has no effect.
REQ-019 SHALL, on the same cycle as the final accept and a new sum_valid, not accept the load; it is accepted the next cycle in IDLE.

Reset
REQ-020 SHALL, on asynchronous rst mid-frame, discard in-flight data immediately: state=IDLE, L=0, counters=0, stage valids=0.
REQ-021 SHALL hold outputs during reset as sum_ready=0, in_ready=0, out_valid=0, out_p=0, out_last=0, done=0; sum_ready=1 on the first cycle after deassertion.

Structure
REQ-022 SHALL place the state enum, the Q1.7 fraction width (7), the ln-sum width (16) and the saturation value (255) in the shared package pseudo_softmax_pkg.
REQ-023 SHALL implement REQ-013 as combinational sub-module pow2_mitchell (17-bit t in, 8-bit p out), instantiated once.

Verification
REQ-024 SHALL cover: sum_exp=10, sum_mant=128, N=4, x=10,9,8,0 with out_ready=1 -> out_p=255,128,64,0, last on the 4th, done one cycle later.
REQ-025 SHALL cover: sum_exp=10, sum_mant=192, x=10 -> out_p=192; x=11 -> 255 (saturate).
REQ-026 SHALL cover: N=3 with out_ready low 5 cycles after the first in accept -> in_ready drops once the pipeline is full, outputs are held stable, and exactly 3 outputs come in order.
REQ-027 SHALL cover: frame_len=0 -> 256 elements accepted; out_last only on #256.
REQ-028 SHALL cover: rst pulsed after 2 of 4 elements -> all outputs are 0 asynchronously, no further out_valid, and sum_ready=1 after release.
REQ-029 SHALL cover: sum_valid held high during RUN -> no reload; the next frame loads the first cycle of IDLE.
